// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one data-memory SRAM between the CPU load/store port (m0)
// and a second master (m1). One access is accepted per cycle. The SRAM's
// active-low controls are driven straight from the granted request, and the
// owning master gets a fixed one-cycle-latency response.
//
// Handshake: a request beat transfers on a rising edge where mN_req_valid and
// mN_req_ready are both high. Ready is combinational from valid and the
// arbiter state, is never high without its valid, and is held low during
// reset. Responses (mN_resp_valid) cannot be back-pressured.
module dm_arbiter #(
  parameter int unsigned BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic        m0_req_write,
  input  logic [15:0] m0_req_addr,
  input  logic [31:0] m0_req_wdata,
  input  logic [3:0]  m0_req_wstrb,
  output logic        m0_resp_valid,
  output logic [31:0] m0_resp_rdata,
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic        m1_req_write,
  input  logic [15:0] m1_req_addr,
  input  logic [31:0] m1_req_wdata,
  input  logic [3:0]  m1_req_wstrb,
  output logic        m1_resp_valid,
  output logic [31:0] m1_resp_rdata,
  output logic        sram_ceb,
  output logic        sram_web,
  output logic [31:0] sram_bweb,
  output logic [13:0] sram_a,
  output logic [31:0] sram_di,
  input  logic [31:0] sram_do,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] BMAX = 4'(BURST_MAX);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        last_winner, last_winner_n;  // 0 = m0, 1 = m1
  logic        grant0, grant1;
  logic        accept;
  logic        winner;
  logic        rsp_vld, rsp_id, rsp_rd;

  logic        sel_write;
  logic [15:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;

  // Byte address bits [1:0] carry no information for word accesses.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^{m0_req_addr[1:0], m1_req_addr[1:0]};

  assign dbg_state = state;

  // Grant selection: the owner keeps the port until its burst quota is used
  // up while the other master waits; ties from IDLE go to the master that
  // did not win last time.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (m0_req_valid && m1_req_valid) begin
            if (last_winner) grant0 = 1'b1;
            else             grant1 = 1'b1;
          end else if (m0_req_valid) begin
            grant0 = 1'b1;
          end else if (m1_req_valid) begin
            grant1 = 1'b1;
          end
        end
        OWN0: begin
          if (m0_req_valid && ((cnt < BMAX) || !m1_req_valid)) grant0 = 1'b1;
          else if (m1_req_valid)                                grant1 = 1'b1;
        end
        OWN1: begin
          if (m1_req_valid && ((cnt < BMAX) || !m0_req_valid)) grant1 = 1'b1;
          else if (m0_req_valid)                                grant0 = 1'b1;
        end
        default: begin
          grant0 = 1'b0;
          grant1 = 1'b0;
        end
      endcase
    end
  end

  assign accept       = grant0 | grant1;
  assign winner       = grant1;
  assign m0_req_ready = grant0;
  assign m1_req_ready = grant1;

  // Next ownership: extend the owner's burst, switch owner on a hand-over,
  // or fall back to IDLE on a cycle with no accept.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    last_winner_n = last_winner;
    if (accept) begin
      if ((state == OWN0 && !winner) || (state == OWN1 && winner)) begin
        cnt_n = (cnt < BMAX) ? cnt + 4'd1 : BMAX;
      end else begin
        state_n       = winner ? OWN1 : OWN0;
        cnt_n         = 4'd1;
        last_winner_n = winner;
      end
    end else begin
      state_n = IDLE;
      cnt_n   = 4'd0;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      last_winner <= 1'b1;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      last_winner <= last_winner_n;
    end
  end

  // Mux of the granted master's request fields.
  assign sel_write = grant1 ? m1_req_write : m0_req_write;
  assign sel_addr  = grant1 ? m1_req_addr  : m0_req_addr;
  assign sel_wdata = grant1 ? m1_req_wdata : m0_req_wdata;
  assign sel_wstrb = grant1 ? m1_req_wstrb : m0_req_wstrb;

  // SRAM controls follow the granted request in the same cycle; idle values
  // otherwise. A write with no strobes still cycles the SRAM but masks every bit.
  always_comb begin
    sram_ceb  = 1'b1;
    sram_web  = 1'b1;
    sram_bweb = '1;
    sram_a    = '0;
    sram_di   = '0;
    if (accept) begin
      sram_ceb = 1'b0;
      sram_a   = sel_addr[15:2];
      sram_di  = sel_wdata;
      if (sel_write) begin
        sram_web = 1'b0;
        for (int i = 0; i < 4; i++) begin
          sram_bweb[8*i +: 8] = sel_wstrb[i] ? 8'h00 : 8'hFF;
        end
      end
    end
  end

  // Remember who was accepted and whether it was a read, for the response
  // that appears in the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld <= 1'b0;
      rsp_id  <= 1'b0;
      rsp_rd  <= 1'b0;
    end else begin
      rsp_vld <= accept;
      rsp_id  <= winner;
      rsp_rd  <= ~sel_write;
    end
  end

  // Responses are suppressed while reset is asserted so a beat accepted just
  // before reset never reports back.
  assign m0_resp_valid = !rst && rsp_vld && !rsp_id;
  assign m1_resp_valid = !rst && rsp_vld &&  rsp_id;
  assign m0_resp_rdata = (m0_resp_valid && rsp_rd) ? sram_do : 32'h0;
  assign m1_resp_rdata = (m1_resp_valid && rsp_rd) ? sram_do : 32'h0;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed bench for dm_arbiter with a behavioural SRAM, a
// reference memory and a response scoreboard.
module tb_dm_arbiter;

  localparam int BURST_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_valid, m0_req_ready, m0_req_write;
  logic [15:0] m0_req_addr;
  logic [31:0] m0_req_wdata;
  logic [3:0]  m0_req_wstrb;
  logic        m0_resp_valid;
  logic [31:0] m0_resp_rdata;
  logic        m1_req_valid, m1_req_ready, m1_req_write;
  logic [15:0] m1_req_addr;
  logic [31:0] m1_req_wdata;
  logic [3:0]  m1_req_wstrb;
  logic        m1_resp_valid;
  logic [31:0] m1_resp_rdata;
  logic        sram_ceb, sram_web;
  logic [31:0] sram_bweb;
  logic [13:0] sram_a;
  logic [31:0] sram_di;
  logic [31:0] sram_do = 32'h0;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard entry: {master id, expected rdata}.
  logic [32:0] exp_q[$];
  logic        acc_log[$];
  logic [31:0] ref_mem [int];
  logic [31:0] sram_mem [int];

  dm_arbiter #(.BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready),
    .m0_req_write(m0_req_write), .m0_req_addr(m0_req_addr),
    .m0_req_wdata(m0_req_wdata), .m0_req_wstrb(m0_req_wstrb),
    .m0_resp_valid(m0_resp_valid), .m0_resp_rdata(m0_resp_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready),
    .m1_req_write(m1_req_write), .m1_req_addr(m1_req_addr),
    .m1_req_wdata(m1_req_wdata), .m1_req_wstrb(m1_req_wstrb),
    .m1_resp_valid(m1_resp_valid), .m1_resp_rdata(m1_resp_rdata),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_bweb(sram_bweb),
    .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do),
    .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [31:0] sram_rd(input int a);
    return sram_mem.exists(a) ? sram_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  // Behavioural SRAM: samples on the rising edge, read data in the next cycle.
  always @(posedge clk) begin
    if (!sram_ceb) begin
      if (!sram_web)
        sram_mem[int'(sram_a)] = (sram_rd(int'(sram_a)) & sram_bweb) | (sram_di & ~sram_bweb);
      else
        sram_do <= sram_rd(int'(sram_a));
    end
  end

  // Record an accepted beat in the reference memory and the expected queue.
  task automatic record(input logic id, input logic wr, input logic [15:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    int w;
    logic [31:0] v;
    w = int'(a[15:2]);
    acc_log.push_back(id);
    if (wr) begin
      v = ref_rd(w);
      for (int i = 0; i < 4; i++) if (s[i]) v[8*i +: 8] = d[8*i +: 8];
      ref_mem[w] = v;
      exp_q.push_back({id, 32'h0});
    end else begin
      exp_q.push_back({id, ref_rd(w)});
    end
  endtask

  // Scoreboard monitor: compare responses, check handshake rules, log accepts.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst) begin
      exp_q.delete();
      chk("rst_m0_resp_valid", 32'(m0_resp_valid), 32'h0);
      chk("rst_m1_resp_valid", 32'(m1_resp_valid), 32'h0);
      chk("rst_m0_ready", 32'(m0_req_ready), 32'h0);
      chk("rst_m1_ready", 32'(m1_req_ready), 32'h0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_m0_resp_valid", 32'(m0_resp_valid), 32'(e[32] == 1'b0));
      chk("sb_m1_resp_valid", 32'(m1_resp_valid), 32'(e[32] == 1'b1));
      chk("sb_m0_resp_rdata", m0_resp_rdata, e[32] ? 32'h0 : e[31:0]);
      chk("sb_m1_resp_rdata", m1_resp_rdata, e[32] ? e[31:0] : 32'h0);
    end else begin
      chk("sb_idle_m0_resp_valid", 32'(m0_resp_valid), 32'h0);
      chk("sb_idle_m1_resp_valid", 32'(m1_resp_valid), 32'h0);
    end
    chk("ready_onehot", 32'(m0_req_ready & m1_req_ready), 32'h0);
    chk("ready_needs_valid", 32'((m0_req_ready & !m0_req_valid) | (m1_req_ready & !m1_req_valid)), 32'h0);
    if (m0_req_valid && m0_req_ready)
      record(1'b0, m0_req_write, m0_req_addr, m0_req_wdata, m0_req_wstrb);
    if (m1_req_valid && m1_req_ready)
      record(1'b1, m1_req_write, m1_req_addr, m1_req_wdata, m1_req_wstrb);
  end

  // Driver tasks.
  task automatic drive0(input logic v, input logic wr, input logic [15:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    m0_req_valid = v; m0_req_write = wr; m0_req_addr = a;
    m0_req_wdata = d; m0_req_wstrb = s;
  endtask

  task automatic drive1(input logic v, input logic wr, input logic [15:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    m1_req_valid = v; m1_req_write = wr; m1_req_addr = a;
    m1_req_wdata = d; m1_req_wstrb = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int found;

    // Reset with both masters requesting.
    rst = 1'b1;
    drive0(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0);
    drive1(1'b1, 1'b0, 16'h0040, 32'h0, 4'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("reset_m0_ready", 32'(m0_req_ready), 32'h0);
      chk("reset_m1_ready", 32'(m1_req_ready), 32'h0);
      chk("reset_ceb", 32'(sram_ceb), 32'h1);
      chk("reset_bweb", sram_bweb, 32'hFFFFFFFF);
      chk("reset_m0_rdata", m0_resp_rdata, 32'h0);
      tick();
    end
    rst = 1'b0;
    drive0(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    drive1(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("post_reset_state", 32'(dbg_state), 32'h0);
    tick();

    // m0 full write then read back.
    drive0(1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    chk("wr0_ready", 32'(m0_req_ready), 32'h1);
    chk("wr0_ceb", 32'(sram_ceb), 32'h0);
    chk("wr0_a", 32'(sram_a), 32'h0004);
    chk("wr0_web", 32'(sram_web), 32'h0);
    chk("wr0_bweb", sram_bweb, 32'h0);
    chk("wr0_di", sram_di, 32'hDEADBEEF);
    tick();
    drive0(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0);
    @(negedge clk);
    chk("wr0_resp_valid", 32'(m0_resp_valid), 32'h1);
    chk("rd0_web", 32'(sram_web), 32'h1);
    chk("rd0_bweb", sram_bweb, 32'hFFFFFFFF);
    tick();
    drive0(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("rd0_resp_valid", 32'(m0_resp_valid), 32'h1);
    chk("rd0_rdata", m0_resp_rdata, 32'hDEADBEEF);
    chk("idle_ceb", 32'(sram_ceb), 32'h1);
    tick();

    // m1 full write, partial write, read back.
    drive1(1'b1, 1'b1, 16'h0040, 32'h11223344, 4'hF);
    @(negedge clk);
    chk("wr1_ready", 32'(m1_req_ready), 32'h1);
    tick();
    drive1(1'b1, 1'b1, 16'h0040, 32'hAABBCCDD, 4'b0101);
    @(negedge clk);
    chk("pw1_web", 32'(sram_web), 32'h0);
    chk("pw1_bweb", sram_bweb, 32'hFF00FF00);
    tick();
    drive1(1'b1, 1'b0, 16'h0040, 32'h0, 4'h0);
    @(negedge clk);
    chk("rd1_a", 32'(sram_a), 32'h0010);
    tick();
    drive1(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("rd1_rdata", m1_resp_rdata, 32'h11BB33DD);
    chk("rd1_m0_quiet", 32'(m0_resp_valid), 32'h0);
    tick();

    // Zero-strobe write is acknowledged and changes nothing.
    drive1(1'b1, 1'b1, 16'h0040, 32'h00000000, 4'h0);
    @(negedge clk);
    chk("zs_ceb", 32'(sram_ceb), 32'h0);
    chk("zs_bweb", sram_bweb, 32'hFFFFFFFF);
    tick();
    drive1(1'b1, 1'b0, 16'h0040, 32'h0, 4'h0);
    tick();
    drive1(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("zs_rdata", m1_resp_rdata, 32'h11BB33DD);
    tick();

    // Contention from reset: m0 x4, m1 x4, m0 x4.
    rst = 1'b1;
    drive0(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0);
    drive1(1'b1, 1'b0, 16'h0040, 32'h0, 4'h0);
    tick();
    rst = 1'b0;
    acc_log.delete();
    repeat (12) tick();
    drive0(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    drive1(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    chk("cont_count", 32'(acc_log.size()), 32'd12);
    for (int i = 0; i < 12 && i < acc_log.size(); i++)
      chk($sformatf("cont_winner_%0d", i), 32'(acc_log[i]), 32'((i / BURST_MAX) % 2));
    tick();

    // Lone m1 for 10 cycles, then m0 joins.
    acc_log.delete();
    drive1(1'b1, 1'b0, 16'h0040, 32'h0, 4'h0);
    repeat (10) tick();
    chk("lone_count", 32'(acc_log.size()), 32'd10);
    for (int i = 0; i < 10 && i < acc_log.size(); i++)
      chk($sformatf("lone_winner_%0d", i), 32'(acc_log[i]), 32'h1);
    acc_log.delete();
    drive0(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0);
    repeat (BURST_MAX + 2) tick();
    found = -1;
    for (int i = 0; i < acc_log.size(); i++)
      if (acc_log[i] == 1'b0 && found < 0) found = i;
    chk("lone_handover", 32'(found >= 0 && found <= BURST_MAX), 32'h1);
    drive0(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    drive1(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    tick();

    // Reset right after an m0 read accept.
    drive0(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0);
    @(negedge clk);
    chk("mid_rd_ready", 32'(m0_req_ready), 32'h1);
    tick();
    drive0(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_resp_valid", 32'(m0_resp_valid), 32'h0);
    chk("mid_rst_resp_rdata", m0_resp_rdata, 32'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_state", 32'(dbg_state), 32'h0);
    chk("mid_rst_no_resp", 32'(m0_resp_valid), 32'h0);
    tick();
    drive0(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0);
    drive1(1'b1, 1'b0, 16'h0040, 32'h0, 4'h0);
    @(negedge clk);
    chk("tie_m0_ready", 32'(m0_req_ready), 32'h1);
    chk("tie_m1_ready", 32'(m1_req_ready), 32'h0);
    tick();
    drive0(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    drive1(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    repeat (2) tick();
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
